// File: rtl/ic_dport_mh.sv
// ic_dport_mh: debug-port interconnect between the DMI and up to CPU_MAX harts.
// Holds the hart-selection registers, fans each DMI request out to its target
// harts one at a time (lowest index first) and merges their responses.
module ic_dport_mh #(
    parameter int CPU_MAX   = 4,
    parameter int ADDR_BITS = 12,
    parameter int DATA_BITS = 64,
    localparam int HSB      = (CPU_MAX > 1) ? $clog2(CPU_MAX) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_nrst,
    input  logic                          i_hartsel_we,
    input  logic [HSB-1:0]                i_hartsel,
    input  logic                          i_hasel,
    input  logic                          i_hawindow_we,
    input  logic [CPU_MAX-1:0]            i_hawindow,
    input  logic [CPU_MAX-1:0]            i_available,
    output logic [HSB-1:0]                o_hartsel,
    output logic [CPU_MAX-1:0]            o_hawindow,
    input  logic                          i_req_valid,
    output logic                          o_req_ready,
    input  logic                          i_req_write,
    input  logic [ADDR_BITS-1:0]          i_req_addr,
    input  logic [DATA_BITS-1:0]          i_req_wdata,
    output logic                          o_resp_valid,
    input  logic                          i_resp_ready,
    output logic [DATA_BITS-1:0]          o_resp_rdata,
    output logic                          o_resp_error,
    output logic [CPU_MAX-1:0]            o_dport_req_valid,
    input  logic [CPU_MAX-1:0]            i_dport_req_ready,
    output logic                          o_dport_write,
    output logic [ADDR_BITS-1:0]          o_dport_addr,
    output logic [DATA_BITS-1:0]          o_dport_wdata,
    input  logic [CPU_MAX-1:0]            i_dport_resp_valid,
    output logic [CPU_MAX-1:0]            o_dport_resp_ready,
    input  logic [CPU_MAX*DATA_BITS-1:0]  i_dport_rdata,
    input  logic [CPU_MAX-1:0]            i_dport_resp_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [HSB-1:0]         hartsel_q, hartsel_d;
    logic                   hasel_q, hasel_d;
    logic [CPU_MAX-1:0]     hawindow_q, hawindow_d;
    logic [CPU_MAX-1:0]     mask_q, mask_d;
    logic [HSB-1:0]         cur_q, cur_d;
    logic                   err_q, err_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   write_q, write_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;

    logic [CPU_MAX-1:0]     sel_onehot;
    logic [CPU_MAX-1:0]     cur_onehot;
    logic [CPU_MAX-1:0]     tgt_mask;
    logic [CPU_MAX-1:0]     mask_left;
    logic                   cur_req_ready;
    logic                   cur_resp_valid;
    logic                   cur_resp_error;
    logic [DATA_BITS-1:0]   cur_rdata;

    // Index of the lowest set bit; harts are always served in ascending order.
    function automatic logic [HSB-1:0] lowest_bit(input logic [CPU_MAX-1:0] m);
        lowest_bit = '0;
        for (int k = CPU_MAX - 1; k >= 0; k--) begin
            if (m[k]) lowest_bit = HSB'(k);
        end
    endfunction

    // Decode hartsel and the current hart into one-hot form and mux that hart's handshake inputs.
    always_comb begin
        sel_onehot     = '0;
        cur_onehot     = '0;
        cur_req_ready  = 1'b0;
        cur_resp_valid = 1'b0;
        cur_resp_error = 1'b0;
        cur_rdata      = '0;
        for (int k = 0; k < CPU_MAX; k++) begin
            if (int'(hartsel_q) == k) sel_onehot[k] = 1'b1;
            if (int'(cur_q) == k) begin
                cur_onehot[k]  = 1'b1;
                cur_req_ready  = i_dport_req_ready[k];
                cur_resp_valid = i_dport_resp_valid[k];
                cur_resp_error = i_dport_resp_error[k];
                cur_rdata      = i_dport_rdata[k*DATA_BITS +: DATA_BITS];
            end
        end
        tgt_mask = ((i_req_write && hasel_q) ? (hawindow_q | sel_onehot) : sel_onehot) & i_available;
    end

    // Selection registers load whenever their write-enable is high, regardless of FSM state.
    always_comb begin
        hartsel_d  = i_hartsel_we  ? i_hartsel  : hartsel_q;
        hasel_d    = i_hartsel_we  ? i_hasel    : hasel_q;
        hawindow_d = i_hawindow_we ? i_hawindow : hawindow_q;
    end

    // Transaction sequencer: latch request, walk the target mask one hart at a time, then respond.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        cur_d     = cur_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_left = mask_q & ~cur_onehot;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    write_d = i_req_write;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    mask_d  = tgt_mask;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    if (tgt_mask == '0) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cur_d   = lowest_bit(tgt_mask);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (cur_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cur_resp_valid) begin
                    err_d  = err_q | cur_resp_error;
                    if (!write_q) rdata_d = cur_rdata;
                    mask_d = mask_left;
                    if (mask_left == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        cur_d   = lowest_bit(mask_left);
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_RESP: begin
                if (i_resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            hartsel_q  <= '0;
            hasel_q    <= 1'b0;
            hawindow_q <= '0;
            mask_q     <= '0;
            cur_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hartsel_q  <= hartsel_d;
            hasel_q    <= hasel_d;
            hawindow_q <= hawindow_d;
            mask_q     <= mask_d;
            cur_q      <= cur_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign o_hartsel          = hartsel_q;
    assign o_hawindow         = hawindow_q;
    assign o_req_ready        = (state_q == ST_IDLE);
    assign o_resp_valid       = (state_q == ST_RESP);
    assign o_resp_error       = (state_q == ST_RESP) && err_q;
    assign o_resp_rdata       = ((state_q == ST_RESP) && !err_q && !write_q) ? rdata_q : '0;
    assign o_dport_req_valid  = (state_q == ST_ISSUE) ? cur_onehot : '0;
    assign o_dport_resp_ready = (state_q == ST_WAIT)  ? cur_onehot : '0;
    assign o_dport_write      = write_q;
    assign o_dport_addr       = addr_q;
    assign o_dport_wdata      = wdata_q;

endmodule
